// File: rtl/register_bank_mp.sv
// Multi-port register bank with hardware clear after reset, write-port priority,
// optional same-cycle forwarding and optional registered read ports.
module register_bank_mp #(
    parameter int NUM_READ_PORTS  = 2,
    parameter int NUM_WRITE_PORTS = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int DEPTH           = 64,
    parameter bit READ_REGISTERED = 1'b0,
    parameter bit BYPASS          = 1'b1,
    localparam int ADDR_W         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NUM_WRITE_PORTS-1:0][ADDR_W-1:0]      write_addr,
    input  logic [NUM_WRITE_PORTS-1:0][DATA_WIDTH-1:0]  new_data,
    input  logic [NUM_WRITE_PORTS-1:0]                  commit,
    input  logic [NUM_READ_PORTS-1:0][ADDR_W-1:0]       read_addr,
    output logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0]   data,
    output logic                                        init_done,
    output logic                                        write_conflict
);

    typedef enum logic {INIT, READY} state_t;

    state_t                                     state;
    state_t                                     state_next;
    logic [ADDR_W-1:0]                          init_count;
    logic [DATA_WIDTH-1:0]                      mem [DEPTH];
    logic [NUM_WRITE_PORTS-1:0]                 wr_ok;
    logic                                       conflict;
    logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0]  stored;
    logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0]  fwd;

    // Entry 0 is hardwired to zero and addresses past DEPTH do not exist.
    function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
        return (a != '0) && (int'(a) < DEPTH);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= INIT;
            init_count <= '0;
        end else begin
            state <= state_next;
            if (state == INIT) begin
                init_count <= init_count + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        if (state == INIT && int'(init_count) == DEPTH - 1) begin
            state_next = READY;
        end
    end

    always_comb begin
        init_done = (state == READY);
    end

    always_comb begin
        for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
            wr_ok[p] = rst && (state == READY) && commit[p] && addr_valid(write_addr[p]);
        end
    end

    always_comb begin
        conflict = 1'b0;
        for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
            for (int q = p + 1; q < NUM_WRITE_PORTS; q++) begin
                if (wr_ok[p] && wr_ok[q] && write_addr[p] == write_addr[q]) begin
                    conflict = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            write_conflict <= 1'b0;
        end else begin
            write_conflict <= conflict;
        end
    end

    // Later ports are issued last, so the highest-indexed port wins a collision.
    always_ff @(posedge clk) begin
        if (rst && state == INIT) begin
            mem[init_count] <= '0;
        end
        for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
            if (wr_ok[p]) begin
                mem[write_addr[p]] <= new_data[p];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_READ_PORTS; r++) begin
            stored[r] = '0;
            if (state == READY && addr_valid(read_addr[r])) begin
                stored[r] = mem[read_addr[r]];
            end
            fwd[r] = stored[r];
            for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
                if (wr_ok[p] && write_addr[p] == read_addr[r]) begin
                    fwd[r] = new_data[p];
                end
            end
        end
    end

    // Registered reads reuse the forwarding path to get write-first behaviour.
    if (READ_REGISTERED) begin : g_read_reg
        logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0] data_q;
        always_ff @(posedge clk) begin
            if (!rst || state == INIT) begin
                data_q <= '0;
            end else begin
                data_q <= fwd;
            end
        end
        assign data = data_q;
    end else if (BYPASS) begin : g_read_fwd
        assign data = fwd;
    end else begin : g_read_plain
        assign data = stored;
    end

`ifndef SYNTHESIS
    logic [NUM_WRITE_PORTS-1:0] early_commit;
    always_comb begin
        for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
            early_commit[p] = commit[p] && (write_addr[p] != '0);
        end
    end

    a_commit_before_init : assert property (@(posedge clk) disable iff (!rst)
        !(!init_done && (|early_commit)))
        else $error("commit to a nonzero address before init_done");
`endif

endmodule

// File: tb/tb_register_bank_mp.sv
// Directed bench for register_bank_mp: four instances share stimulus to cover
// forwarding, plain combinational read, registered read and a non-power-of-2 depth.
module tb_register_bank_mp;

    logic             clk;
    logic             rst;
    logic [1:0][5:0]  waddr;
    logic [1:0][31:0] wdata;
    logic [1:0]       commit;
    logic [1:0][5:0]  raddr;

    logic [1:0][31:0] data_a, data_b, data_c, data_d;
    logic             done_a, done_b, done_c, done_d;
    logic             wc_a, wc_b, wc_c, wc_d;

    int n_checks = 0;
    int n_pass   = 0;

    register_bank_mp #(.READ_REGISTERED(1'b0), .BYPASS(1'b1)) dut_a (
        .clk(clk), .rst(rst), .write_addr(waddr), .new_data(wdata), .commit(commit),
        .read_addr(raddr), .data(data_a), .init_done(done_a), .write_conflict(wc_a));

    register_bank_mp #(.READ_REGISTERED(1'b0), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst(rst), .write_addr(waddr), .new_data(wdata), .commit(commit),
        .read_addr(raddr), .data(data_b), .init_done(done_b), .write_conflict(wc_b));

    register_bank_mp #(.READ_REGISTERED(1'b1), .BYPASS(1'b1)) dut_c (
        .clk(clk), .rst(rst), .write_addr(waddr), .new_data(wdata), .commit(commit),
        .read_addr(raddr), .data(data_c), .init_done(done_c), .write_conflict(wc_c));

    register_bank_mp #(.DEPTH(48)) dut_d (
        .clk(clk), .rst(rst), .write_addr(waddr), .new_data(wdata), .commit(commit),
        .read_addr(raddr), .data(data_d), .init_done(done_d), .write_conflict(wc_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic idle_writes();
        commit = 2'b00;
        waddr  = '0;
        wdata  = '0;
    endtask

    // Counts rising edges from rst release until dut_a reports init_done.
    task automatic wait_init(output int cnt, output int cnt_d);
        cnt   = 0;
        cnt_d = 0;
        while (!done_a && cnt < 200) begin
            @(posedge clk);
            #1;
            cnt++;
            if (done_d && cnt_d == 0) cnt_d = cnt;
            if (cnt == 10) begin
                check("init_read_zero_a", data_a[0], 32'h0);
                check("init_read_zero_c", data_c[0], 32'h0);
            end
        end
    endtask

    initial begin
        int cnt;
        int cnt_d;

        rst   = 1'b0;
        raddr = '0;
        idle_writes();

        // Garbage commits while held in reset must be discarded.
        repeat (3) begin
            @(negedge clk);
            commit = 2'b11;
            waddr[0] = 6'd5;  wdata[0] = 32'hBAD0_0001;
            waddr[1] = 6'd17; wdata[1] = 32'hBAD0_0002;
        end
        @(negedge clk);
        check("reset_init_done", {31'b0, done_a}, 32'd0);
        check("reset_conflict", {31'b0, wc_a}, 32'd0);
        check("reset_regdata", data_c[0], 32'h0);

        rst = 1'b1;
        idle_writes();
        raddr[0] = 6'd5;
        wait_init(cnt, cnt_d);
        check("init_cycles", 32'(cnt), 32'd64);
        check("init_cycles_depth48", 32'(cnt_d), 32'd48);

        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            raddr[0] = 6'(i);
            #1;
            check($sformatf("cleared_%0d", i), data_a[0], 32'h0);
        end

        // Same-address write from both ports: port 1 wins and a conflict pulses.
        @(negedge clk);
        commit = 2'b11;
        waddr[0] = 6'd5; wdata[0] = 32'hDEADBEEF;
        waddr[1] = 6'd5; wdata[1] = 32'h12345678;
        raddr[0] = 6'd5;
        #1;
        check("conflict_fwd", data_a[0], 32'h12345678);
        check("conflict_nofwd_old", data_b[0], 32'h0);
        check("conflict_before_edge", {31'b0, wc_a}, 32'd0);
        @(posedge clk);
        #1;
        check("conflict_pulse", {31'b0, wc_a}, 32'd1);
        check("conflict_regread", data_c[0], 32'h12345678);
        @(negedge clk);
        idle_writes();
        #1;
        check("conflict_stored", data_b[0], 32'h12345678);
        @(posedge clk);
        #1;
        check("conflict_cleared", {31'b0, wc_a}, 32'd0);

        // Forwarding vs. plain read, two read ports on the same entry.
        @(negedge clk);
        commit = 2'b01;
        waddr[0] = 6'd9; wdata[0] = 32'hA5A5A5A5;
        raddr[0] = 6'd9;
        raddr[1] = 6'd9;
        #1;
        check("bypass_r0", data_a[0], 32'hA5A5A5A5);
        check("bypass_r1", data_a[1], 32'hA5A5A5A5);
        check("nobypass_old", data_b[0], 32'h0);
        @(posedge clk);
        #1;
        check("single_write_no_conflict", {31'b0, wc_a}, 32'd0);
        @(negedge clk);
        idle_writes();
        #1;
        check("nobypass_new", data_b[0], 32'hA5A5A5A5);

        // Writes to entry 0 are dropped and never flagged.
        @(negedge clk);
        commit = 2'b11;
        waddr[0] = 6'd0; wdata[0] = 32'hFFFFFFFF;
        waddr[1] = 6'd0; wdata[1] = 32'hFFFFFFFF;
        raddr[0] = 6'd0;
        #1;
        check("addr0_no_fwd", data_a[0], 32'h0);
        @(posedge clk);
        #1;
        check("addr0_no_conflict", {31'b0, wc_a}, 32'd0);
        @(negedge clk);
        idle_writes();
        #1;
        check("addr0_read", data_a[0], 32'h0);
        check("addr0_regread", data_c[0], 32'h0);

        // Registered read is write-first on the same edge.
        @(negedge clk);
        commit = 2'b01;
        waddr[0] = 6'd3; wdata[0] = 32'h00000042;
        raddr[0] = 6'd3;
        #1;
        check("regread_before_edge", data_c[0], 32'h0);
        @(posedge clk);
        #1;
        check("regread_write_first", data_c[0], 32'h00000042);
        @(negedge clk);
        idle_writes();

        // Address beyond DEPTH=48 neither stores nor forwards.
        @(negedge clk);
        commit = 2'b01;
        waddr[0] = 6'd50; wdata[0] = 32'h00000077;
        raddr[1] = 6'd50;
        #1;
        check("oob_no_fwd_d", data_d[1], 32'h0);
        check("inrange_fwd_a", data_a[1], 32'h00000077);
        @(negedge clk);
        idle_writes();
        #1;
        check("oob_read_d", data_d[1], 32'h0);
        check("inrange_read_a", data_a[1], 32'h00000077);

        // Reset in the middle of a clear restarts it from entry 0.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        raddr[0] = 6'd3;
        repeat (30) @(posedge clk);
        #1;
        check("midinit_not_done", {31'b0, done_a}, 32'd0);
        check("midinit_regdata", data_c[0], 32'h0);
        @(negedge clk);
        rst = 1'b0;
        commit = 2'b01;
        waddr[0] = 6'd9; wdata[0] = 32'hBAD0_0003;
        @(negedge clk);
        rst = 1'b1;
        idle_writes();
        wait_init(cnt, cnt_d);
        check("reinit_cycles", 32'(cnt), 32'd64);
        @(negedge clk);
        raddr[0] = 6'd9;
        raddr[1] = 6'd5;
        #1;
        check("reinit_addr9", data_a[0], 32'h0);
        check("reinit_addr5", data_a[1], 32'h0);
        @(negedge clk);
        raddr[0] = 6'd3;
        raddr[1] = 6'd50;
        #1;
        check("reinit_addr3", data_a[0], 32'h0);
        check("reinit_addr50", data_a[1], 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
